// File: rtl/optflow_pkg.sv
// rtl/optflow_pkg.sv - shared widths, accumulator state enum and saturating add
package optflow_pkg;

  localparam int GRAD_WIDTH_DEF  = 8;
  localparam int ACCUM_WIDTH_DEF = 32;
  localparam int NUM_PRODUCTS    = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } acc_state_e;

  // Adds two sign-extended operands and clamps the result to a signed range
  // of 'width' bits; the result stays sign-extended to 64 bits.
  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int                 width
  );
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (width - 1));
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/window_accumulator_if.sv
// rtl/window_accumulator_if.sv - gradient stream in, window sums out
interface window_accumulator_if
  import optflow_pkg::*;
#(
  parameter int GRAD_WIDTH  = GRAD_WIDTH_DEF,
  parameter int ACCUM_WIDTH = ACCUM_WIDTH_DEF
);
  logic signed [GRAD_WIDTH-1:0]  grad_Ix;
  logic signed [GRAD_WIDTH-1:0]  grad_Iy;
  logic signed [GRAD_WIDTH-1:0]  grad_It;
  logic                          grad_valid;
  logic                          window_clear;
  logic signed [ACCUM_WIDTH-1:0] sum_IxIx;
  logic signed [ACCUM_WIDTH-1:0] sum_IyIy;
  logic signed [ACCUM_WIDTH-1:0] sum_IxIy;
  logic signed [ACCUM_WIDTH-1:0] sum_IxIt;
  logic signed [ACCUM_WIDTH-1:0] sum_IyIt;
  logic                          accum_valid;
  logic                          sat_flag;
  logic                          busy;

  // Gradient source side
  modport master (
    output grad_Ix, grad_Iy, grad_It, grad_valid, window_clear,
    input  sum_IxIx, sum_IyIy, sum_IxIy, sum_IxIt, sum_IyIt,
    input  accum_valid, sat_flag, busy
  );

  // Accumulator side
  modport slave (
    input  grad_Ix, grad_Iy, grad_It, grad_valid, window_clear,
    output sum_IxIx, sum_IyIy, sum_IxIy, sum_IxIt, sum_IyIt,
    output accum_valid, sat_flag, busy
  );
endinterface

// File: rtl/window_accumulator_product_stage.sv
// rtl/window_accumulator_product_stage.sv - product registers, sample counter, last-sample tag
module grad_product_stage
  import optflow_pkg::*;
#(
  parameter int GRAD_WIDTH = GRAD_WIDTH_DEF,
  parameter int N_SAMPLES  = 25
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_valid,
  input  logic                           i_clear,
  input  logic signed [GRAD_WIDTH-1:0]   i_ix,
  input  logic signed [GRAD_WIDTH-1:0]   i_iy,
  input  logic signed [GRAD_WIDTH-1:0]   i_it,
  output logic                           o_p_valid,
  output logic                           o_p_last,
  output logic signed [2*GRAD_WIDTH-1:0] o_prod [NUM_PRODUCTS],
  output logic                           o_cnt_nonzero
);
  localparam int PW    = 2 * GRAD_WIDTH;
  localparam int CNT_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);

  logic [CNT_W-1:0]     r_cnt;
  logic signed [PW-1:0] w_ix;
  logic signed [PW-1:0] w_iy;
  logic signed [PW-1:0] w_it;
  logic signed [PW-1:0] w_prod [NUM_PRODUCTS];

  // Widen operands first so each multiply is full-precision at product width
  assign w_ix = {{GRAD_WIDTH{i_ix[GRAD_WIDTH-1]}}, i_ix};
  assign w_iy = {{GRAD_WIDTH{i_iy[GRAD_WIDTH-1]}}, i_iy};
  assign w_it = {{GRAD_WIDTH{i_it[GRAD_WIDTH-1]}}, i_it};

  assign w_prod[0] = w_ix * w_ix;
  assign w_prod[1] = w_iy * w_iy;
  assign w_prod[2] = w_ix * w_iy;
  assign w_prod[3] = w_ix * w_it;
  assign w_prod[4] = w_iy * w_it;

  assign o_cnt_nonzero = (r_cnt != '0);

  // Capture products per accepted sample; clear beats a coincident sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      o_p_valid <= 1'b0;
      o_p_last  <= 1'b0;
      for (int k = 0; k < NUM_PRODUCTS; k++) o_prod[k] <= '0;
    end else if (i_clear) begin
      r_cnt     <= '0;
      o_p_valid <= 1'b0;
      o_p_last  <= 1'b0;
    end else if (i_valid) begin
      o_p_valid <= 1'b1;
      o_p_last  <= (r_cnt == CNT_LAST);
      r_cnt     <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      for (int k = 0; k < NUM_PRODUCTS; k++) o_prod[k] <= w_prod[k];
    end else begin
      o_p_valid <= 1'b0;
      o_p_last  <= 1'b0;
    end
  end
endmodule

// File: rtl/window_accumulator.sv
// rtl/window_accumulator.sv - structure-tensor window accumulator feeding the flow solver
module window_accumulator
  import optflow_pkg::*;
#(
  parameter int GRAD_WIDTH  = GRAD_WIDTH_DEF,
  parameter int ACCUM_WIDTH = ACCUM_WIDTH_DEF,
  parameter int WINDOW_SIZE = 5
) (
  input logic                clk,
  input logic                rst,
  window_accumulator_if.slave bus
);
  localparam int N  = WINDOW_SIZE * WINDOW_SIZE;
  localparam int PW = 2 * GRAD_WIDTH;

  acc_state_e                    r_state;
  acc_state_e                    w_state_next;
  logic                          w_p_valid;
  logic                          w_p_last;
  logic                          w_cnt_nonzero;
  logic                          w_emit;
  logic                          w_accum_valid;
  logic signed [PW-1:0]          w_prod     [NUM_PRODUCTS];
  logic signed [ACCUM_WIDTH-1:0] r_sum      [NUM_PRODUCTS];
  logic signed [ACCUM_WIDTH-1:0] r_out      [NUM_PRODUCTS];
  logic signed [ACCUM_WIDTH-1:0] w_sum_next [NUM_PRODUCTS];
  logic signed [63:0]            w_a        [NUM_PRODUCTS];
  logic signed [63:0]            w_b        [NUM_PRODUCTS];
  logic signed [63:0]            w_sat      [NUM_PRODUCTS];
  logic [NUM_PRODUCTS-1:0]       w_clip;
  logic                          r_sat_sticky;
  logic                          r_sat_flag;

  grad_product_stage #(
    .GRAD_WIDTH (GRAD_WIDTH),
    .N_SAMPLES  (N)
  ) u_prod (
    .clk           (clk),
    .rst           (rst),
    .i_valid       (bus.grad_valid),
    .i_clear       (bus.window_clear),
    .i_ix          (bus.grad_Ix),
    .i_iy          (bus.grad_Iy),
    .i_it          (bus.grad_It),
    .o_p_valid     (w_p_valid),
    .o_p_last      (w_p_last),
    .o_prod        (w_prod),
    .o_cnt_nonzero (w_cnt_nonzero)
  );

  // Saturating running sum per product; a clip is any result the clamp changed
  for (genvar k = 0; k < NUM_PRODUCTS; k++) begin : g_sum
    assign w_a[k]        = {{(64-ACCUM_WIDTH){r_sum[k][ACCUM_WIDTH-1]}}, r_sum[k]};
    assign w_b[k]        = {{(64-PW){w_prod[k][PW-1]}}, w_prod[k]};
    assign w_sat[k]      = sat_add(w_a[k], w_b[k], ACCUM_WIDTH);
    assign w_clip[k]     = (w_sat[k] != (w_a[k] + w_b[k]));
    assign w_sum_next[k] = w_sat[k][ACCUM_WIDTH-1:0];
  end

  // A clear in the same cycle suppresses the pending emission
  assign w_emit = w_p_valid && w_p_last && !bus.window_clear;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state: clear dominates, then emission, then accumulation
  always_comb begin
    w_state_next = r_state;
    if (bus.window_clear) begin
      w_state_next = ST_IDLE;
    end else if (w_emit) begin
      w_state_next = ST_EMIT;
    end else if (w_p_valid) begin
      w_state_next = ST_ACCUM;
    end else if (r_state == ST_EMIT) begin
      w_state_next = ST_IDLE;
    end
  end

  // State-decoded outputs
  always_comb begin
    w_accum_valid = 1'b0;
    if (r_state == ST_EMIT) w_accum_valid = 1'b1;
  end

  // Running sums, sticky saturation and the held output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_PRODUCTS; k++) begin
        r_sum[k] <= '0;
        r_out[k] <= '0;
      end
      r_sat_sticky <= 1'b0;
      r_sat_flag   <= 1'b0;
    end else if (bus.window_clear) begin
      for (int k = 0; k < NUM_PRODUCTS; k++) r_sum[k] <= '0;
      r_sat_sticky <= 1'b0;
    end else if (w_emit) begin
      for (int k = 0; k < NUM_PRODUCTS; k++) begin
        r_out[k] <= w_sum_next[k];
        r_sum[k] <= '0;
      end
      r_sat_flag   <= r_sat_sticky | (|w_clip);
      r_sat_sticky <= 1'b0;
    end else if (w_p_valid) begin
      for (int k = 0; k < NUM_PRODUCTS; k++) r_sum[k] <= w_sum_next[k];
      r_sat_sticky <= r_sat_sticky | (|w_clip);
    end
  end

  assign bus.sum_IxIx    = r_out[0];
  assign bus.sum_IyIy    = r_out[1];
  assign bus.sum_IxIy    = r_out[2];
  assign bus.sum_IxIt    = r_out[3];
  assign bus.sum_IyIt    = r_out[4];
  assign bus.sat_flag    = r_sat_flag;
  assign bus.accum_valid = w_accum_valid;
  assign bus.busy        = (r_state != ST_IDLE) || w_p_valid || w_cnt_nonzero;
endmodule

// File: tb/tb_window_accumulator.sv
// tb/tb_window_accumulator.sv - randomized model-checked bench at 32- and 17-bit sum widths
module tb_window_accumulator;
  localparam int N = 25;

  typedef struct {
    int ix;
    int iy;
    int it;
  } smp_t;

  typedef struct {
    int     due;
    longint s32 [5];
    longint s17 [5];
    bit     sat32;
    bit     sat17;
  } emit_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int   d_ix = 0;
  int   d_iy = 0;
  int   d_it = 0;
  bit   d_valid = 1'b0;
  bit   d_clear = 1'b0;

  int   n_tests = 0;
  int   n_fail  = 0;

  smp_t   win [$];
  emit_t  pend [$];
  longint held32 [5];
  longint held17 [5];
  bit     hsat32;
  bit     hsat17;
  int     last_acc = -10;

  window_accumulator_if #(.GRAD_WIDTH(8), .ACCUM_WIDTH(32)) if32 ();
  window_accumulator_if #(.GRAD_WIDTH(8), .ACCUM_WIDTH(17)) if17 ();

  window_accumulator #(.GRAD_WIDTH(8), .ACCUM_WIDTH(32), .WINDOW_SIZE(5)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (if32)
  );

  window_accumulator #(.GRAD_WIDTH(8), .ACCUM_WIDTH(17), .WINDOW_SIZE(5)) dut17 (
    .clk (clk),
    .rst (rst),
    .bus (if17)
  );

  assign if32.grad_Ix      = d_ix[7:0];
  assign if32.grad_Iy      = d_iy[7:0];
  assign if32.grad_It      = d_it[7:0];
  assign if32.grad_valid   = d_valid;
  assign if32.window_clear = d_clear;
  assign if17.grad_Ix      = d_ix[7:0];
  assign if17.grad_Iy      = d_iy[7:0];
  assign if17.grad_It      = d_it[7:0];
  assign if17.grad_valid   = d_valid;
  assign if17.window_clear = d_clear;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic longint prod(input smp_t s, input int k);
    case (k)
      0:       return longint'(s.ix * s.ix);
      1:       return longint'(s.iy * s.iy);
      2:       return longint'(s.ix * s.iy);
      3:       return longint'(s.ix * s.it);
      default: return longint'(s.iy * s.it);
    endcase
  endfunction

  // Sum one product over the collected window, clamping after every add
  function automatic longint win_sum(input int w, input int k, output bit sat);
    longint s;
    longint hi;
    longint lo;
    s   = 0;
    sat = 1'b0;
    hi  = (longint'(1) <<< (w - 1)) - 1;
    lo  = -(longint'(1) <<< (w - 1));
    foreach (win[i]) begin
      s = s + prod(win[i], k);
      if (s > hi) begin
        s = hi;
        sat = 1'b1;
      end else if (s < lo) begin
        s = lo;
        sat = 1'b1;
      end
    end
    return s;
  endfunction

  function automatic longint obs32(input int k);
    case (k)
      0:       return if32.sum_IxIx;
      1:       return if32.sum_IyIy;
      2:       return if32.sum_IxIy;
      3:       return if32.sum_IxIt;
      default: return if32.sum_IyIt;
    endcase
  endfunction

  function automatic longint obs17(input int k);
    case (k)
      0:       return if17.sum_IxIx;
      1:       return if17.sum_IyIy;
      2:       return if17.sum_IxIy;
      3:       return if17.sum_IxIt;
      default: return if17.sum_IyIt;
    endcase
  endfunction

  // Compare outputs with the model's view of this cycle, then fold in this cycle's inputs
  always @(negedge clk) begin
    bit   exp_pulse;
    bit   exp_busy;
    bit   s;
    emit_t e;
    if (rst) begin
      win.delete();
      pend.delete();
      for (int k = 0; k < 5; k++) begin
        held32[k] = 0;
        held17[k] = 0;
      end
      hsat32   = 1'b0;
      hsat17   = 1'b0;
      last_acc = -10;
    end
    exp_pulse = (pend.size() > 0) && (pend[0].due == cyc);
    if (exp_pulse) begin
      for (int k = 0; k < 5; k++) begin
        held32[k] = pend[0].s32[k];
        held17[k] = pend[0].s17[k];
      end
      hsat32 = pend[0].sat32;
      hsat17 = pend[0].sat17;
      void'(pend.pop_front());
    end
    exp_busy = (win.size() != 0) || (last_acc == cyc - 1) || exp_pulse;
    chk("w32 accum_valid", if32.accum_valid, exp_pulse);
    chk("w17 accum_valid", if17.accum_valid, exp_pulse);
    chk("w32 busy", if32.busy, exp_busy);
    chk("w17 busy", if17.busy, exp_busy);
    chk("w32 sat_flag", if32.sat_flag, hsat32);
    chk("w17 sat_flag", if17.sat_flag, hsat17);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("w32 sum%0d", k), obs32(k), held32[k]);
      chk($sformatf("w17 sum%0d", k), obs17(k), held17[k]);
    end
    if (!rst) begin
      if (d_clear) begin
        win.delete();
        for (int i = pend.size() - 1; i >= 0; i--)
          if (pend[i].due == cyc + 1) pend.delete(i);
      end else if (d_valid) begin
        win.push_back('{d_ix, d_iy, d_it});
        last_acc = cyc;
        if (win.size() == N) begin
          e.due   = cyc + 2;
          e.sat32 = 1'b0;
          e.sat17 = 1'b0;
          for (int k = 0; k < 5; k++) begin
            e.s32[k] = win_sum(32, k, s);
            e.sat32 |= s;
            e.s17[k] = win_sum(17, k, s);
            e.sat17 |= s;
          end
          pend.push_back(e);
          win.delete();
        end
      end
    end
  end

  task automatic drive(input bit v, input bit c, input int ix, input int iy, input int it);
    @(posedge clk);
    #1;
    d_valid = v;
    d_clear = c;
    d_ix    = ix;
    d_iy    = iy;
    d_it    = it;
  endtask

  function automatic int rnd_grad();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, rnd_grad(), rnd_grad(), rnd_grad());
  endtask

  task automatic sample(input int ix, input int iy, input int it, input int gmin, input int gmax);
    if (gmax > 0) idle(int'($urandom_range(gmin, gmax)));
    drive(1'b1, 1'b0, ix, iy, it);
  endtask

  task automatic samples(input int n, input int ix, input int iy, input int it, input int gmin, input int gmax);
    repeat (n) sample(ix, iy, it, gmin, gmax);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst     = 1'b1;
    d_valid = 1'b0;
    d_clear = 1'b0;
    #1;
    chk("rst accum_valid", if32.accum_valid, 0);
    chk("rst busy32", if32.busy, 0);
    chk("rst busy17", if17.busy, 0);
    chk("rst sum_IxIx32", if32.sum_IxIx, 0);
    chk("rst sum_IxIt17", if17.sum_IxIt, 0);
    chk("rst sat17", if17.sat_flag, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Plain window, then the same with random gaps
    samples(N, 2, 3, -1, 0, 0);
    idle(4);
    samples(N, 2, 3, -1, 1, 3);
    idle(4);

    // Back-to-back windows with no bubble
    samples(N, 1, 0, 0, 0, 0);
    samples(N, -4, 0, 4, 0, 0);
    idle(4);

    // Saturates the 17-bit sums, then a clean window
    samples(N, -128, 0, 0, 0, 0);
    samples(N, 1, 0, 0, 0, 0);
    idle(4);

    // Abort with a coincident sample, then a full window
    repeat (10) sample(rnd_grad(), rnd_grad(), rnd_grad(), 0, 0);
    drive(1'b1, 1'b1, 5, 5, 5);
    samples(N, 1, 1, 1, 0, 0);
    idle(4);

    // Clear on the pending-emission cycle, then clear during the pulse with a new sample
    samples(N, 3, 3, 3, 0, 0);
    drive(1'b0, 1'b1, 0, 0, 0);
    idle(3);
    samples(N, 7, -7, 2, 0, 0);
    sample(9, 9, 9, 0, 0);
    drive(1'b0, 1'b1, 0, 0, 0);
    idle(3);

    // Asynchronous reset mid-window
    samples(12, 5, 6, 7, 0, 0);
    async_reset();
    samples(N, 2, -1, 0, 0, 0);
    idle(4);

    // Random mix of samples, gaps and occasional clears over full-range gradients
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 15) idle(1);
      else if (r < 17) drive(($urandom_range(0, 1) == 1), 1'b1, rnd_grad(), rnd_grad(), rnd_grad());
      else drive(1'b1, 1'b0, rnd_grad(), rnd_grad(), rnd_grad());
    end
    idle(6);
    chk("pending pulses drained", pend.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
